// File: rtl/addsub_arbiter.sv
// addsub_arbiter: shares one external WIDTH-bit carry-chain adder between two
// requesters. Requests are granted round-robin. A subtract is issued to the
// adder as A + ~B + 1. The adder outputs are captured one cycle after the
// operands are driven. One tagged result per operation is returned over a
// valid/ready handshake, together with borrow and signed-overflow flags.
//
// Ports:
//   CLK, RESETN                  clock, synchronous active-low reset
//   REQ0/OP0/A0/B0, ACK0         requester 0 (OP: 0 = add, 1 = subtract)
//   REQ1/OP1/A1/B1, ACK1         requester 1
//   ADD_I0/ADD_I1/ADD_CIN        registered operands to the shared adder
//   ADD_O/ADD_COUT               sum and carry from the shared adder
//   RES/RES_COUT/RES_BORROW/
//   RES_OVF/RES_ID               result payload
//   RES_VALID/RES_READY          result handshake
module addsub_arbiter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             REQ0,
  input  logic             OP0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  output logic             ACK0,
  input  logic             REQ1,
  input  logic             OP1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             ACK1,
  output logic [WIDTH-1:0] ADD_I0,
  output logic [WIDTH-1:0] ADD_I1,
  output logic             ADD_CIN,
  input  logic [WIDTH-1:0] ADD_O,
  input  logic             ADD_COUT,
  output logic [WIDTH-1:0] RES,
  output logic             RES_COUT,
  output logic             RES_BORROW,
  output logic             RES_OVF,
  output logic             RES_ID,
  output logic             RES_VALID,
  input  logic             RES_READY
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             prio;   // 1: requester 1 wins when both request
  logic             op_q;
  logic             id_q;

  logic             grant1;
  logic             sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  always_comb begin
    grant1 = REQ1 & (~REQ0 | prio);
    sel_op = grant1 ? OP1 : OP0;
    sel_a  = grant1 ? A1 : A0;
    sel_b  = grant1 ? B1 : B0;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state      <= IDLE;
      prio       <= 1'b0;
      op_q       <= 1'b0;
      id_q       <= 1'b0;
      ACK0       <= 1'b0;
      ACK1       <= 1'b0;
      ADD_I0     <= '0;
      ADD_I1     <= '0;
      ADD_CIN    <= 1'b0;
      RES        <= '0;
      RES_COUT   <= 1'b0;
      RES_BORROW <= 1'b0;
      RES_OVF    <= 1'b0;
      RES_ID     <= 1'b0;
      RES_VALID  <= 1'b0;
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ0 | REQ1) begin
            ADD_I0  <= sel_a;
            ADD_I1  <= sel_op ? ~sel_b : sel_b;
            ADD_CIN <= sel_op;
            op_q    <= sel_op;
            id_q    <= grant1;
            ACK0    <= ~grant1;
            ACK1    <= grant1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          RES        <= ADD_O;
          RES_COUT   <= ADD_COUT;
          RES_BORROW <= op_q & ~ADD_COUT;
          // Overflow is judged on the operands as issued, so a subtract is
          // checked against the inverted B that actually entered the adder.
          RES_OVF    <= (ADD_I0[WIDTH-1] == ADD_I1[WIDTH-1]) &
                        (ADD_O[WIDTH-1] != ADD_I0[WIDTH-1]);
          RES_ID     <= id_q;
          RES_VALID  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (RES_READY) begin
            RES_VALID <= 1'b0;
            prio      <= ~id_q;  // last-served requester drops to low priority
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed testbench for addsub_arbiter (WIDTH=2) with a behavioural model of
// the external ripple adder closing the loop.
module tb_addsub_arbiter;

  localparam int unsigned W = 2;

  logic         CLK = 1'b0;
  logic         RESETN;
  logic         REQ0, OP0, REQ1, OP1;
  logic [W-1:0] A0, B0, A1, B1;
  logic         ACK0, ACK1;
  logic [W-1:0] ADD_I0, ADD_I1, ADD_O;
  logic         ADD_CIN, ADD_COUT;
  logic [W-1:0] RES;
  logic         RES_COUT, RES_BORROW, RES_OVF, RES_ID, RES_VALID, RES_READY;

  logic [W:0]   sum;

  int checks = 0;
  int errors = 0;

  addsub_arbiter #(.WIDTH(W)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .REQ0(REQ0), .OP0(OP0), .A0(A0), .B0(B0), .ACK0(ACK0),
    .REQ1(REQ1), .OP1(OP1), .A1(A1), .B1(B1), .ACK1(ACK1),
    .ADD_I0(ADD_I0), .ADD_I1(ADD_I1), .ADD_CIN(ADD_CIN),
    .ADD_O(ADD_O), .ADD_COUT(ADD_COUT),
    .RES(RES), .RES_COUT(RES_COUT), .RES_BORROW(RES_BORROW),
    .RES_OVF(RES_OVF), .RES_ID(RES_ID), .RES_VALID(RES_VALID),
    .RES_READY(RES_READY)
  );

  always #5 CLK = ~CLK;

  // External adder model
  assign sum      = {1'b0, ADD_I0} + {1'b0, ADD_I1} + {{W{1'b0}}, ADD_CIN};
  assign ADD_O    = sum[W-1:0];
  assign ADD_COUT = sum[W];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] r, input logic c,
                         input logic b, input logic o, input logic id);
    chk({tag, "_valid"},  {7'd0, RES_VALID}, 8'd1);
    chk({tag, "_res"},    {6'd0, RES}, {6'd0, r});
    chk({tag, "_cout"},   {7'd0, RES_COUT}, {7'd0, c});
    chk({tag, "_borrow"}, {7'd0, RES_BORROW}, {7'd0, b});
    chk({tag, "_ovf"},    {7'd0, RES_OVF}, {7'd0, o});
    chk({tag, "_id"},     {7'd0, RES_ID}, {7'd0, id});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack0"},  {7'd0, ACK0}, 8'd0);
    chk({tag, "_ack1"},  {7'd0, ACK1}, 8'd0);
    chk({tag, "_i0"},    {6'd0, ADD_I0}, 8'd0);
    chk({tag, "_i1"},    {6'd0, ADD_I1}, 8'd0);
    chk({tag, "_cin"},   {7'd0, ADD_CIN}, 8'd0);
    chk({tag, "_res"},   {6'd0, RES}, 8'd0);
    chk({tag, "_flags"}, {4'd0, RES_COUT, RES_BORROW, RES_OVF, RES_ID}, 8'd0);
    chk({tag, "_valid"}, {7'd0, RES_VALID}, 8'd0);
  endtask

  initial begin
    RESETN = 1'b0; RES_READY = 1'b1;
    REQ0 = 1'b0; OP0 = 1'b0; A0 = '0; B0 = '0;
    REQ1 = 1'b0; OP1 = 1'b0; A1 = '0; B1 = '0;
    tick(); tick();
    chk_zero("reset");
    RESETN = 1'b1;

    // Add 3+1 from requester 0
    REQ0 = 1'b1; OP0 = 1'b0; A0 = 2'd3; B0 = 2'd1;
    tick();
    chk("t1_ack0", {7'd0, ACK0}, 8'd1);
    chk("t1_ack1", {7'd0, ACK1}, 8'd0);
    chk("t1_i0",   {6'd0, ADD_I0}, 8'd3);
    chk("t1_i1",   {6'd0, ADD_I1}, 8'd1);
    chk("t1_cin",  {7'd0, ADD_CIN}, 8'd0);
    chk("t1_vld0", {7'd0, RES_VALID}, 8'd0);
    REQ0 = 1'b0;
    tick();
    chk("t1_ackpulse", {7'd0, ACK0}, 8'd0);
    chk_res("t1", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t1_done", {7'd0, RES_VALID}, 8'd0);

    // Subtract 1-2 from requester 1: overflow and borrow
    REQ1 = 1'b1; OP1 = 1'b1; A1 = 2'd1; B1 = 2'd2;
    tick();
    chk("t2_ack1", {7'd0, ACK1}, 8'd1);
    chk("t2_i1",   {6'd0, ADD_I1}, 8'd1);
    chk("t2_cin",  {7'd0, ADD_CIN}, 8'd1);
    REQ1 = 1'b0;
    tick();
    chk_res("t2", 2'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();

    // Subtract 3-1 from requester 1: no borrow
    REQ1 = 1'b1; OP1 = 1'b1; A1 = 2'd3; B1 = 2'd1;
    tick();
    chk("t3_ack1", {7'd0, ACK1}, 8'd1);
    chk("t3_i1",   {6'd0, ADD_I1}, 8'd2);
    REQ1 = 1'b0;
    tick();
    chk_res("t3", 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();

    // Both requesting continuously: grants alternate 0,1,0,1 every 3 cycles
    REQ0 = 1'b1; OP0 = 1'b0; A0 = 2'd1; B0 = 2'd1;
    REQ1 = 1'b1; OP1 = 1'b0; A1 = 2'd1; B1 = 2'd0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("rr_ack0_%0d", k), {7'd0, ACK0},
          {7'd0, (k % 3 == 0) && ((k / 3) % 2 == 0)});
      chk($sformatf("rr_ack1_%0d", k), {7'd0, ACK1},
          {7'd0, (k % 3 == 0) && ((k / 3) % 2 == 1)});
      chk($sformatf("rr_vld_%0d", k), {7'd0, RES_VALID}, {7'd0, k % 3 == 1});
      if (k % 3 == 1)
        chk($sformatf("rr_id_%0d", k), {7'd0, RES_ID}, {7'd0, (k / 3) % 2 == 1});
    end
    REQ0 = 1'b0; REQ1 = 1'b0; RES_READY = 1'b0;

    // Stalled consumer with requester 0 pending
    REQ1 = 1'b1; OP1 = 1'b0; A1 = 2'd1; B1 = 2'd1;
    tick();
    chk("st_ack1", {7'd0, ACK1}, 8'd1);
    REQ1 = 1'b0;
    REQ0 = 1'b1; OP0 = 1'b0; A0 = 2'd2; B0 = 2'd2;
    tick();
    chk_res("st", 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("st_hold_vld_%0d", k), {7'd0, RES_VALID}, 8'd1);
      chk($sformatf("st_hold_res_%0d", k), {6'd0, RES}, 8'd2);
      chk($sformatf("st_hold_ack0_%0d", k), {7'd0, ACK0}, 8'd0);
    end
    RES_READY = 1'b1;
    tick();
    chk("st_release_vld", {7'd0, RES_VALID}, 8'd0);
    chk("st_release_ack0", {7'd0, ACK0}, 8'd0);
    tick();
    chk("st_ack0", {7'd0, ACK0}, 8'd1);
    REQ0 = 1'b0;
    tick();
    chk_res("st2", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();

    // Reset during EXEC; pointer (now favouring 1) must return to requester 0
    REQ1 = 1'b1; OP1 = 1'b1; A1 = 2'd3; B1 = 2'd1;
    tick();
    chk("rs_ack1", {7'd0, ACK1}, 8'd1);
    RESETN = 1'b0;
    REQ0 = 1'b1; OP0 = 1'b0; A0 = 2'd1; B0 = 2'd2;
    tick();
    chk_zero("rs_exec");
    tick();
    chk("rs_hold_vld", {7'd0, RES_VALID}, 8'd0);
    RESETN = 1'b1;
    tick();
    chk("rs_ack0", {7'd0, ACK0}, 8'd1);
    chk("rs_ack1b", {7'd0, ACK1}, 8'd0);
    chk("rs_i0", {6'd0, ADD_I0}, 8'd1);
    chk("rs_i1", {6'd0, ADD_I1}, 8'd2);
    REQ0 = 1'b0;
    tick();
    chk_res("rs", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rs_next_ack1", {7'd0, ACK1}, 8'd1);
    REQ1 = 1'b0;
    tick();
    chk_res("rs2", 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
